pipe_hazard_scoreboard: RTL and testbench
=========================================

Name: pipe_hazard_scoreboard

Overview:
Sequential hazard, stall and forwarding controller for the 5-stage pipeline. It replaces the purely combinational ID-stage hazard logic and adds three things that logic lacks:
- a register scoreboard and issue sequencer for one variable-latency multi-cycle unit (MUL/DIV);
- a memory-wait freeze FSM driven by MIO ready;
- parametrised register-file size.
It sits beside the ID stage and drives the stage enables, bubble/flush controls and forwarding muxes.

Parameters:
- NREG, 32, number of architectural registers (register 0 hard-wired zero).
- RAW, 5, register address width; NREG must be <= 2**RAW.
- CNT_W, 4, multi-cycle latency counter width.
- MAX_LAT, 8, maximum legal multi-cycle latency; must be < 2**CNT_W.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs, id_rt  in  RAW  source registers
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_wr_en, id_wr_addr  in  1/RAW  ID instruction destination
- id_is_mc  in  1  ID instruction goes to the multi-cycle unit
- id_mc_lat  in  CNT_W  its latency L
- ex_wr_en, ex_wr_addr, ex_is_load  in  1/RAW/1  EX-stage producer info
- mem_wr_en, mem_wr_addr, mem_is_load  in  1/RAW/1  MEM-stage producer info
- mem_access  in  1  MEM stage performs a load/store
- mem_ready  in  1  MIO ready
- branch_taken  in  1  ID resolved a taken jump/branch
- stall_if, stall_id  out  1  hold PC / IF-ID register
- bubble_ex  out  1  insert NOP into ID/EX
- freeze_ex_mem  out  1  hold ID/EX, EX/MEM, MEM/WB
- flush_if  out  1  squash IF-ID register
- fwd_rs_sel, fwd_rt_sel  out  2  0=regfile, 1=EX ALU, 2=MEM ALU, 3=MEM load data
- mc_start  out  1  one-cycle start pulse to the multi-cycle unit
- mc_wb_valid, mc_wb_addr  out  1/RAW  multi-cycle result write, on a dedicated regfile port
- mc_busy  out  1  multi-cycle FSM not IDLE

Behaviour:
Reset and matching rules
- On reset (async, rst_n low) all outputs are 0, the scoreboard is cleared, and both FSMs go to IDLE/RUN.
- Register 0 never matches: no hazard, no forwarding for it.
- "Source match" means id_uses_x && addr==src && src!=0.

Forwarding (combinational)
- Per source: EX producer with !ex_is_load -> 1.
- Otherwise MEM producer -> 2 if !mem_is_load, else 3.
- Otherwise 0.
- EX has priority over MEM.

Hazard terms (combinational, all qualified by id_valid)
- load_use: ex_wr_en && ex_is_load && source match on ex_wr_addr.
- sb_raw: scoreboard bit set for a matched source.
- sb_waw: id_wr_en && scoreboard bit set for id_wr_addr.
- mc_struct: id_is_mc && mc FSM not IDLE.
- hz = load_use | sb_raw | sb_waw | mc_struct.

Memory FSM (RUN, WAIT)
- RUN -> WAIT when mem_access && !mem_ready. Outputs in that cycle are already the freeze outputs (combinational on mem_ready).
- WAIT -> RUN on the first cycle with mem_ready=1.
- While frozen (WAIT, or RUN with mem_access && !mem_ready):
  - stall_if = stall_id = freeze_ex_mem = 1;
  - bubble_ex = flush_if = 0;
  - no mc issue is accepted.
- Not frozen:
  - stall_if = stall_id = hz;
  - bubble_ex = hz;
  - freeze_ex_mem = 0;
  - flush_if = branch_taken && !hz.

Multi-cycle FSM (IDLE, BUSY, WB)
- Issue is accepted when id_valid && id_is_mc && !hz && !frozen. On accept:
  - mc_start = 1 that cycle;
  - counter <= max(L,1) - 1, where L = id_mc_lat;
  - dest latched;
  - scoreboard[dest] set (if id_wr_en and dest != 0);
  - go to BUSY.
- BUSY: the counter decrements every cycle, including frozen cycles. At 0, go to WB.
- WB: one cycle with mc_wb_valid = 1 and mc_wb_addr = dest. The scoreboard bit clears at the end of this cycle, so dependents stall through WB and release the next cycle. Then go to IDLE.
- Result timing: issue at cycle t gives mc_wb_valid at cycle t + L.
- L > MAX_LAT is clamped to MAX_LAT.
- Async reset mid-operation abandons the op and clears the scoreboard.

Optional Feature:
HAZ_STATS_EN
- Defined: adds outputs stat_load_use, stat_mc, stat_memwait (32 bits each). Each increments once per cycle its cause stalls ID; memwait takes precedence over the others, load_use over mc. They saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. lw $5 in EX, ID uses rs=$5 -> stall_if = stall_id = bubble_ex = 1 for 1 cycle. Next cycle, with the load in MEM, fwd_rs_sel = 3 and no stall.
2. add $3 in EX and add $3 in MEM, ID reads rt=$3 -> fwd_rt_sel = 1. Same case with dest $0 -> fwd_rt_sel = 0.
3. mul issue to $7 with L=4 at cycle 10 -> mc_start at 10, mc_wb_valid with addr 7 at cycle 14. A reader of $7 stalls cycles 11–14 and proceeds at 15.
4. Second mul in ID while the first is BUSY -> stalled until the cycle after WB, then mc_start.
5. mem_access with mem_ready low for 3 cycles -> freeze_ex_mem = stall_if = 1 for exactly 3 cycles. A concurrent branch_taken gives flush_if = 0 until the freeze releases.
6. Pulse rst_n low while BUSY -> scoreboard cleared, mc_busy = 0, no mc_wb_valid afterwards.

Source files
------------

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard, stall and forwarding controller with multi-cycle scoreboard.
// Optional HAZ_STATS_EN adds saturating stall-cause counters.
module pipe_hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int RAW     = 5,
  parameter int CNT_W   = 4,
  parameter int MAX_LAT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic           id_uses_rs,
  input  logic           id_uses_rt,
  input  logic           id_wr_en,
  input  logic [RAW-1:0] id_wr_addr,
  input  logic           id_is_mc,
  input  logic [CNT_W-1:0] id_mc_lat,
  input  logic           ex_wr_en,
  input  logic [RAW-1:0] ex_wr_addr,
  input  logic           ex_is_load,
  input  logic           mem_wr_en,
  input  logic [RAW-1:0] mem_wr_addr,
  input  logic           mem_is_load,
  input  logic           mem_access,
  input  logic           mem_ready,
  input  logic           branch_taken,
  output logic           stall_if,
  output logic           stall_id,
  output logic           bubble_ex,
  output logic           freeze_ex_mem,
  output logic           flush_if,
  output logic [1:0]     fwd_rs_sel,
  output logic [1:0]     fwd_rt_sel,
  output logic           mc_start,
  output logic           mc_wb_valid,
  output logic [RAW-1:0] mc_wb_addr,
  output logic           mc_busy
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]    stat_load_use,
  output logic [31:0]    stat_mc,
  output logic [31:0]    stat_memwait
`endif
);

  localparam int SBN = 1 << RAW;
  localparam logic [CNT_W-1:0] MaxLat = CNT_W'(MAX_LAT);
  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  typedef enum logic [1:0] {MC_IDLE, MC_BUSY, MC_WB} mcState_t;
  typedef enum logic {MEM_RUN, MEM_WAIT} memState_t;

  mcState_t mcState, mcNext;
  memState_t memState, memNext;

  logic [SBN-1:0]   sb;
  logic [CNT_W-1:0] cnt;
  logic [RAW-1:0]   dest;
  logic [CNT_W-1:0] latEff;

  logic rsNz, rtNz;
  logic rsEx, rtEx, rsMem, rtMem;
  logic loadUse, sbRaw, sbWaw, mcStruct, hz;
  logic frozen, accept, destOk;

  always_comb begin
    rsNz  = id_uses_rs && (id_rs != '0);
    rtNz  = id_uses_rt && (id_rt != '0);
    rsEx  = rsNz && (id_rs == ex_wr_addr) && ex_wr_en;
    rtEx  = rtNz && (id_rt == ex_wr_addr) && ex_wr_en;
    rsMem = rsNz && (id_rs == mem_wr_addr) && mem_wr_en;
    rtMem = rtNz && (id_rt == mem_wr_addr) && mem_wr_en;
  end

  always_comb begin
    fwd_rs_sel = 2'd0;
    fwd_rt_sel = 2'd0;
    if (rsEx && !ex_is_load) fwd_rs_sel = 2'd1;
    else if (rsMem) fwd_rs_sel = mem_is_load ? 2'd3 : 2'd2;
    if (rtEx && !ex_is_load) fwd_rt_sel = 2'd1;
    else if (rtMem) fwd_rt_sel = mem_is_load ? 2'd3 : 2'd2;
  end

  always_comb begin
    loadUse  = id_valid && ex_is_load && (rsEx || rtEx);
    sbRaw    = id_valid && ((rsNz && sb[id_rs]) || (rtNz && sb[id_rt]));
    sbWaw    = id_valid && id_wr_en && sb[id_wr_addr];
    mcStruct = id_valid && id_is_mc && (mcState != MC_IDLE);
    hz       = loadUse || sbRaw || sbWaw || mcStruct;
    frozen   = !mem_ready && ((memState == MEM_WAIT) || mem_access);
    accept   = id_valid && id_is_mc && !hz && !frozen;
    destOk   = id_wr_en && (id_wr_addr != '0) && (int'(id_wr_addr) < NREG);
  end

  always_comb begin
    latEff = id_mc_lat;
    if (id_mc_lat > MaxLat) latEff = MaxLat;
    else if (id_mc_lat == '0) latEff = One;
  end

  always_comb begin
    memNext = memState;
    unique case (memState)
      MEM_RUN:  if (mem_access && !mem_ready) memNext = MEM_WAIT;
      MEM_WAIT: if (mem_ready) memNext = MEM_RUN;
      default:  memNext = MEM_RUN;
    endcase
  end

  // L==1 skips BUSY so the result still lands exactly L cycles after issue
  always_comb begin
    mcNext = mcState;
    unique case (mcState)
      MC_IDLE: if (accept) mcNext = (latEff == One) ? MC_WB : MC_BUSY;
      MC_BUSY: if (cnt == One) mcNext = MC_WB;
      MC_WB:   mcNext = MC_IDLE;
      default: mcNext = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memState <= MEM_RUN;
      mcState  <= MC_IDLE;
      cnt      <= '0;
      dest     <= '0;
      sb       <= '0;
    end else begin
      memState <= memNext;
      mcState  <= mcNext;
      if (accept) begin
        cnt  <= latEff - One;
        dest <= id_wr_addr;
        if (destOk) sb[id_wr_addr] <= 1'b1;
      end else if (mcState == MC_BUSY) begin
        cnt <= cnt - One;
      end
      if (mcState == MC_WB) sb[dest] <= 1'b0;
    end
  end

  always_comb begin
    stall_if      = hz;
    stall_id      = hz;
    bubble_ex     = hz;
    freeze_ex_mem = 1'b0;
    flush_if      = branch_taken && !hz;
    if (frozen) begin
      stall_if      = 1'b1;
      stall_id      = 1'b1;
      bubble_ex     = 1'b0;
      freeze_ex_mem = 1'b1;
      flush_if      = 1'b0;
    end
    mc_start    = accept;
    mc_wb_valid = (mcState == MC_WB);
    mc_wb_addr  = (mcState == MC_WB) ? dest : '0;
    mc_busy     = (mcState != MC_IDLE);
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_load_use <= '0;
      stat_mc       <= '0;
      stat_memwait  <= '0;
    end else if (frozen) begin
      if (stat_memwait != '1) stat_memwait <= stat_memwait + 32'd1;
    end else if (loadUse) begin
      if (stat_load_use != '1) stat_load_use <= stat_load_use + 32'd1;
    end else if (sbRaw || sbWaw || mcStruct) begin
      if (stat_mc != '1) stat_mc <= stat_mc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard: per-cycle expected output vectors
// are queued with the stimulus and compared on the falling edge.
module tb_pipe_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt;
  logic       id_uses_rs, id_uses_rt;
  logic       id_wr_en;
  logic [4:0] id_wr_addr;
  logic       id_is_mc;
  logic [3:0] id_mc_lat;
  logic       ex_wr_en, ex_is_load;
  logic [4:0] ex_wr_addr;
  logic       mem_wr_en, mem_is_load;
  logic [4:0] mem_wr_addr;
  logic       mem_access, mem_ready, branch_taken;
  logic       stall_if, stall_id, bubble_ex, freeze_ex_mem, flush_if;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic       mc_start, mc_wb_valid, mc_busy;
  logic [4:0] mc_wb_addr;
`ifdef HAZ_STATS_EN
  logic [31:0] stat_load_use, stat_mc, stat_memwait;
`endif

  pipe_hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .id_is_mc(id_is_mc), .id_mc_lat(id_mc_lat),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
    .ex_is_load(ex_is_load),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_is_load(mem_is_load),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .branch_taken(branch_taken),
    .stall_if(stall_if), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .freeze_ex_mem(freeze_ex_mem),
    .flush_if(flush_if),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .mc_start(mc_start), .mc_wb_valid(mc_wb_valid),
    .mc_wb_addr(mc_wb_addr), .mc_busy(mc_busy)
`ifdef HAZ_STATS_EN
    ,
    .stat_load_use(stat_load_use), .stat_mc(stat_mc),
    .stat_memwait(stat_memwait)
`endif
  );

  typedef struct {
    string      tag;
    logic [16:0] v;
  } expT;

  expT q[$];
  int errCnt = 0;
  int chkCnt = 0;

  wire [16:0] got = {stall_if, stall_id, bubble_ex, freeze_ex_mem,
                     flush_if, fwd_rs_sel, fwd_rt_sel, mc_start,
                     mc_wb_valid, mc_wb_addr, mc_busy};

  task automatic checkVal(input string tag, input logic [16:0] obs,
                          input logic [16:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    expT x;
    if (q.size() > 0) begin
      x = q.pop_front();
      checkVal(x.tag, got, x.v);
    end
  end

  // Vector layout: stall_if, stall_id, bubble, freeze, flush,
  // fwd_rs, fwd_rt, start, wb_valid, wb_addr, busy
  function automatic logic [16:0] ev(
    input logic st, input logic bub, input logic frz, input logic fl,
    input logic [1:0] frs, input logic [1:0] frt, input logic start,
    input logic wbv, input logic [4:0] wba, input logic busy);
    return {st, st, bub, frz, fl, frs, frt, start, wbv, wba, busy};
  endfunction

  task automatic step(input string tag, input logic [16:0] v);
    expT x;
    x.tag = tag;
    x.v = v;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    id_valid = 0; id_rs = 0; id_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0;
    id_wr_en = 0; id_wr_addr = 0;
    id_is_mc = 0; id_mc_lat = 0;
    ex_wr_en = 0; ex_wr_addr = 0; ex_is_load = 0;
    mem_wr_en = 0; mem_wr_addr = 0; mem_is_load = 0;
    mem_access = 0; mem_ready = 1; branch_taken = 0;
  endtask

  localparam logic [16:0] Z = 17'd0;
  localparam logic [16:0] STALL = 17'h1C000;

  initial begin
    rst_n = 0;
    idleIn();
    @(posedge clk);
    #1;
    step("rst0", Z);
    step("rst1", Z);
    rst_n = 1;
    step("idle", Z);

    // load-use
    idleIn();
    id_valid = 1; id_uses_rs = 1; id_rs = 5;
    ex_wr_en = 1; ex_wr_addr = 5; ex_is_load = 1;
    step("lu_stall", ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    ex_wr_en = 0; ex_is_load = 0;
    mem_wr_en = 1; mem_wr_addr = 5; mem_is_load = 1;
    step("lu_fwd3", ev(0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
    idleIn();
    id_valid = 1; id_uses_rt = 1; id_rt = 9;
    ex_wr_en = 1; ex_wr_addr = 9; ex_is_load = 1;
    step("lu_rt", ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    id_uses_rt = 0;
    step("lu_unused", Z);
    id_uses_rs = 1; id_rs = 0; ex_wr_addr = 0;
    step("lu_reg0", Z);
    id_valid = 0; id_uses_rs = 1; id_rs = 9; ex_wr_addr = 9;
    step("lu_novalid", Z);

    // ALU forwarding
    idleIn();
    id_valid = 1; id_uses_rt = 1; id_rt = 3;
    ex_wr_en = 1; ex_wr_addr = 3;
    mem_wr_en = 1; mem_wr_addr = 3;
    step("fwd_ex", ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    ex_wr_en = 0;
    step("fwd_mem", ev(0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    ex_wr_en = 1; id_rt = 0; ex_wr_addr = 0; mem_wr_addr = 0;
    step("fwd_reg0", Z);

    // branch flush, suppressed by a hazard
    idleIn();
    id_valid = 1; branch_taken = 1;
    step("flush", ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    id_uses_rs = 1; id_rs = 2;
    ex_wr_en = 1; ex_wr_addr = 2; ex_is_load = 1;
    step("flush_hz", ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    // mul to $7, L=4
    idleIn();
    id_valid = 1; id_is_mc = 1; id_mc_lat = 4;
    id_wr_en = 1; id_wr_addr = 7;
    step("mc_issue", ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    idleIn();
    id_valid = 1; id_uses_rs = 1; id_rs = 7;
    step("raw_b1", ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    idleIn();
    id_valid = 1; id_wr_en = 1; id_wr_addr = 7;
    step("waw_b2", ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    idleIn();
    id_valid = 1; id_uses_rt = 1; id_rt = 7;
    step("raw_b3", ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    step("raw_wb", ev(1, 1, 0, 0, 0, 0, 0, 1, 5'd7, 1));
    step("raw_rel", Z);

    // back-to-back muls: structural stall, then L=0 acts as L=1
    idleIn();
    id_valid = 1; id_is_mc = 1; id_mc_lat = 2;
    id_wr_en = 1; id_wr_addr = 9;
    step("mc1_issue", ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    id_wr_addr = 10; id_mc_lat = 0;
    step("mc2_busy", ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    step("mc2_wb1", ev(1, 1, 0, 0, 0, 0, 0, 1, 5'd9, 1));
    step("mc2_go", ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    idleIn();
    step("mc2_wb", ev(0, 0, 0, 0, 0, 0, 0, 1, 5'd10, 1));
    step("mc2_idle", Z);

    // latency clamp: L=15 behaves as 8
    idleIn();
    id_valid = 1; id_is_mc = 1; id_mc_lat = 15;
    id_wr_en = 1; id_wr_addr = 4;
    step("clamp_issue", ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    idleIn();
    for (int i = 1; i < 8; i++)
      step("clamp_busy", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step("clamp_wb", ev(0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 1));
    step("clamp_idle", Z);

    // memory wait: 3 frozen cycles, branch and mc issue held off
    idleIn();
    id_valid = 1; branch_taken = 1;
    id_is_mc = 1; id_mc_lat = 3;
    mem_access = 1; mem_ready = 0;
    step("frz1", ev(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    mem_access = 0;
    step("frz2", ev(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step("frz3", ev(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    mem_ready = 1; id_is_mc = 0;
    step("frz_rel", ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    idleIn();
    step("frz_after", Z);

    // reset in the middle of a multi-cycle op
    idleIn();
    id_valid = 1; id_is_mc = 1; id_mc_lat = 6;
    id_wr_en = 1; id_wr_addr = 12;
    step("rst_issue", ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    idleIn();
    step("rst_busy1", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step("rst_busy2", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    rst_n = 0;
    step("rst_mid", Z);
    rst_n = 1;
    id_valid = 1; id_uses_rs = 1; id_rs = 12;
    for (int i = 0; i < 6; i++)
      step("post_rst", Z);

    if (STALL == Z) $display("unreachable");
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
